rst_sched: RTL
==============

RST_SCHED -- requirements
Module: rst_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the reset generator (2..8).
REQ-002 Parameter HOLD_CYC, default 8: cycles out_fsm_rst stays high after in_rst is seen high (1..255).
REQ-003 Parameter TIMEOUT, default 16: maximum wait cycles in ASSERT or RELEASE (1..255).
REQ-004 in_clk  input  1  single clock; all logic on its rising edge.
REQ-005 in_rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_req  input  N_REQ  level request per requester, held until its ack.
REQ-007 in_rst  input  1  reset-active status returned by the shared reset generator.
REQ-008 out_fsm_rst  output  1  reset command driven to the shared reset generator.
REQ-009 out_ack  output  N_REQ  one-cycle completion pulse to the owning requester.
REQ-010 out_err  output  1  one-cycle pulse, coincident with out_ack, on timeout.
REQ-011 out_busy  output  1  high in every state except IDLE.
REQ-012 out_owner  output  clog2(N_REQ)  index of the current or most recent owner.
REQ-013 out_err_cnt  output  8  saturating count of timeouts.

Function
REQ-014 The FSM SHALL have the states IDLE, ASSERT, HOLD, RELEASE, DONE and FAIL, all registered.
REQ-015 IDLE: if any in_req bit is high, the block SHALL grant round-robin starting at index rr_ptr, latch out_owner, set rr_ptr to owner+1 mod N_REQ, clear the timer, and go to ASSERT on the next cycle.
REQ-016 ASSERT: out_fsm_rst=1, timer increments each cycle; in_rst=1 -> HOLD with the timer cleared; timer reaching TIMEOUT with in_rst=0 -> FAIL.
REQ-017 HOLD: out_fsm_rst=1 for exactly HOLD_CYC cycles, then RELEASE with the timer cleared; in_rst is ignored in HOLD.
REQ-018 RELEASE: out_fsm_rst=0; in_rst=0 -> DONE; timer reaching TIMEOUT with in_rst=1 -> FAIL.
REQ-019 DONE: out_ack[out_owner]=1 and out_err=0 for one cycle, then IDLE.
REQ-020 FAIL: out_fsm_rst=0, out_ack[out_owner]=1 and out_err=1 for one cycle, out_err_cnt increments (saturating at 255), then IDLE.
REQ-021 out_fsm_rst and out_ack SHALL be register outputs with no combinational path from any input.
REQ-022 Only one out_ack bit SHALL ever be high, and only in DONE or FAIL.
REQ-023 A requester that drops in_req while it owns the generator SHALL NOT abort the sequence; it still receives out_ack.
REQ-024 Requests arriving while out_busy=1 SHALL wait; the grant is evaluated only in IDLE, so at least one IDLE cycle separates consecutive sequences.
REQ-025 After its ack, a requester that still holds in_req SHALL be re-granted only after every other pending requester has been served once.
REQ-026 Timer and hold counter SHALL be 8 bits and SHALL NOT wrap while waiting.

Reset
REQ-027 While in_rst_n=0: state=IDLE, out_fsm_rst=0, out_ack=0, out_err=0, out_busy=0, out_owner=0, rr_ptr=0, timer=0, out_err_cnt=0.
REQ-028 in_rst_n asserted mid-sequence SHALL abort immediately without ack; operation resumes from IDLE on the first clock edge after release.

Verification
REQ-029 in_req=0001, generator returns in_rst=1 two cycles after out_fsm_rst rises and in_rst=0 two cycles after it falls -> out_fsm_rst high for 2+8 cycles, then out_ack=0001 with out_err=0, out_busy low after ack.
REQ-030 in_req=1111 held continuously, well-behaved generator -> acks in order 0001, 0010, 0100, 1000, then 0001; out_owner=0,1,2,3,0.
REQ-031 in_rst stuck at 0 -> FAIL after 16 ASSERT cycles; out_ack=owner bit, out_err=1, out_err_cnt=1, out_fsm_rst=0.
REQ-032 in_rst stuck at 1 -> FAIL after HOLD and then 16 RELEASE cycles; out_err=1.
REQ-033 Run 256 forced timeouts -> out_err_cnt stays at 255.
REQ-034 in_rst_n pulsed low during HOLD -> out_fsm_rst=0 at once, no ack, out_err_cnt=0; pending in_req=0010 is granted after release.

Source files
------------

// File: rtl/rst_sched.sv
// rtl/rst_sched.sv - round-robin scheduler sharing one reset generator among N_REQ requesters
module rst_sched #(
    parameter int N_REQ    = 4,
    parameter int HOLD_CYC = 8,
    parameter int TIMEOUT  = 16,
    localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic [N_REQ-1:0] in_req,
    input  logic             in_rst,
    output logic             out_fsm_rst,
    output logic [N_REQ-1:0] out_ack,
    output logic             out_err,
    output logic             out_busy,
    output logic [OW-1:0]    out_owner,
    output logic [7:0]       out_err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [OW-1:0] PTR_LAST = OW'(N_REQ - 1);

    state_t            state, state_nx;
    logic [7:0]        timer, timer_nx;
    logic [7:0]        hold_cnt, hold_nx;
    logic [OW-1:0]     rr_ptr, rr_nx;
    logic [OW-1:0]     owner, owner_nx;
    logic              found;
    logic [OW-1:0]     grant_idx;
    logic [OW:0]       rr_sum;
    logic [N_REQ-1:0]  ack_nx;

    // Search starts at rr_ptr and wraps, so the last owner is considered last.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_sum = {1'b0, rr_ptr} + (OW+1)'(i);
            if (rr_sum >= (OW+1)'(N_REQ)) begin
                rr_sum = rr_sum - (OW+1)'(N_REQ);
            end
            if (!found && in_req[rr_sum[OW-1:0]]) begin
                found     = 1'b1;
                grant_idx = rr_sum[OW-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        hold_nx  = hold_cnt;
        rr_nx    = rr_ptr;
        owner_nx = owner;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    owner_nx = grant_idx;
                    rr_nx    = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
                    timer_nx = '0;
                    state_nx = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (in_rst) begin
                    timer_nx = '0;
                    hold_nx  = '0;
                    state_nx = ST_HOLD;
                end else if (timer == TO_LAST) begin
                    state_nx = ST_FAIL;
                end else begin
                    timer_nx = timer + 8'd1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    timer_nx = '0;
                    state_nx = ST_RELEASE;
                end else begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            ST_RELEASE: begin
                if (!in_rst) begin
                    state_nx = ST_DONE;
                end else if (timer == TO_LAST) begin
                    state_nx = ST_FAIL;
                end else begin
                    timer_nx = timer + 8'd1;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            ST_FAIL:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_nx = '0;
        if (state_nx == ST_DONE || state_nx == ST_FAIL) begin
            ack_nx[owner_nx] = 1'b1;
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            hold_cnt    <= '0;
            rr_ptr      <= '0;
            owner       <= '0;
            out_fsm_rst <= 1'b0;
            out_ack     <= '0;
            out_err     <= 1'b0;
            out_err_cnt <= '0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            hold_cnt    <= hold_nx;
            rr_ptr      <= rr_nx;
            owner       <= owner_nx;
            out_fsm_rst <= (state_nx == ST_ASSERT) || (state_nx == ST_HOLD);
            out_ack     <= ack_nx;
            out_err     <= (state_nx == ST_FAIL);
            if (state_nx == ST_FAIL && out_err_cnt != 8'hFF) begin
                out_err_cnt <= out_err_cnt + 8'd1;
            end
        end
    end

    assign out_busy  = (state != ST_IDLE);
    assign out_owner = owner;

endmodule
